// File: rtl/regfile_2w2r_sb.sv
// Two-write/two-read register file with hardwired-zero x0, preset register, optional
// write-to-read bypass, per-register busy scoreboard and a sequenced clear after reset.
module regfile_2w2r_sb #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned AW         = 5,
  parameter int unsigned PRESET_IDX = 8,
  parameter int unsigned PRESET_VAL = 17,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [XLEN-1:0] wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd1,
  input  logic            alloc,
  input  logic [AW-1:0]   alloc_addr,
  output logic            ready
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  localparam logic [AW-1:0]   LastIdx    = AW'(NREGS - 1);
  localparam logic [AW-1:0]   PresetAddr = AW'(PRESET_IDX);
  localparam logic [XLEN-1:0] PresetData = XLEN'(PRESET_VAL);
  localparam bit              PresetEn   = (PRESET_IDX != 0);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;

  logic run, wr0, wr1;

  assign run   = (state_q == StRun);
  assign ready = run;
  assign wr0   = run && we0 && (wa0 != '0);
  assign wr1   = run && we1 && (wa1 != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    busy_d  = busy_q;
    unique case (state_q)
      StInit: begin
        regs_d[cnt_q] = (PresetEn && cnt_q == PresetAddr) ? PresetData : '0;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LastIdx) state_d = StRun;
      end
      StRun: begin
        // Port 1 is applied last so it wins an address collision; alloc is applied
        // after the write clears so a same-edge alloc leaves the register busy.
        if (wr0) begin
          regs_d[wa0] = wd0;
          busy_d[wa0] = 1'b0;
        end
        if (wr1) begin
          regs_d[wa1] = wd1;
          busy_d[wa1] = 1'b0;
        end
        if (alloc) busy_d[alloc_addr] = 1'b1;
        busy_d[0] = 1'b0;
      end
      default: state_d = StInit;
    endcase
  end

  // Register contents are deliberately left untouched by reset; the init sweep clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      regs_q  <= regs_d;
    end
  end

  logic [AW-1:0]   ra   [2];
  logic [XLEN-1:0] rdat [2];
  logic            rbsy [2];

  assign ra[0] = a1;
  assign ra[1] = a2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rdat[p] = regs_q[ra[p]];
      if (BYPASS && we0 && wa0 == ra[p]) rdat[p] = wd0;
      if (BYPASS && we1 && wa1 == ra[p]) rdat[p] = wd1;
      if (!run || ra[p] == '0) rdat[p] = '0;
      rbsy[p] = run && busy_q[ra[p]];
    end
  end

  assign rd1   = rdat[0];
  assign rd2   = rdat[1];
  assign busy1 = rbsy[0];
  assign busy2 = rbsy[1];

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Randomized self-checking bench: two instances (bypass on/off) driven in lockstep and
// compared against an architectural register/scoreboard model.
module tb_regfile_2w2r_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, we0, we1, alloc;
  logic [AW-1:0]   a1, a2, wa0, wa1, alloc_addr;
  logic [XLEN-1:0] wd0, wd1;
  logic [XLEN-1:0] rd1, rd2, nb_rd1, nb_rd2;
  logic            busy1, busy2, ready, nb_busy1, nb_busy2, nb_ready;

  regfile_2w2r_sb #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .alloc(alloc), .alloc_addr(alloc_addr),
    .ready(ready)
  );

  regfile_2w2r_sb #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .a1(a1), .a2(a2), .rd1(nb_rd1), .rd2(nb_rd2),
    .busy1(nb_busy1), .busy2(nb_busy2), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .alloc(alloc), .alloc_addr(alloc_addr),
    .ready(nb_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Architectural model: what a program would observe, not how the RTL sequences it.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  bit              m_ready = 1'b0;
  int              m_init_idx = 0;

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (!m_ready || a == 0) return '0;
    if (byp && we1 && wa1 == a) return wd1;
    if (byp && we0 && wa0 == a) return wd0;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    return m_ready && m_busy[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_ready    = 1'b0;
      m_init_idx = 0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else if (!m_ready) begin
      m_regs[m_init_idx] = (m_init_idx == 8) ? 32'd17 : 32'd0;
      m_init_idx++;
      if (m_init_idx == NREGS) m_ready = 1'b1;
    end else begin
      if (we0 && wa0 != 0) begin m_regs[wa0] = wd0; m_busy[wa0] = 1'b0; end
      if (we1 && wa1 != 0) begin m_regs[wa1] = wd1; m_busy[wa1] = 1'b0; end
      if (alloc && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic check_all();
    #1;
    check("ready", ready, m_ready);
    check("nb_ready", nb_ready, m_ready);
    check("rd1", rd1, exp_rd(a1, 1'b1));
    check("rd2", rd2, exp_rd(a2, 1'b1));
    check("nb_rd1", nb_rd1, exp_rd(a1, 1'b0));
    check("nb_rd2", nb_rd2, exp_rd(a2, 1'b0));
    check("busy1", busy1, exp_busy(a1));
    check("busy2", busy2, exp_busy(a2));
    check("nb_busy1", nb_busy1, exp_busy(a1));
  endtask

  task automatic idle();
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0; alloc = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
    return AW'($urandom);
  endfunction

  initial begin
    rst = 1'b1; we0 = 1'b0; we1 = 1'b0; alloc = 1'b0;
    a1 = '0; a2 = '0; wa0 = '0; wa1 = '0; alloc_addr = '0; wd0 = '0; wd1 = '0;
    tick();
    rst = 1'b0;

    // Init sweep: ready low for exactly NREGS edges, busy clear everywhere.
    for (int i = 0; i < NREGS; i++) begin
      a1 = AW'(i);
      check_all();
      check("init_ready_low", ready, 0);
      tick();
    end
    a1 = 5'd8; a2 = 5'd5;
    check_all();
    check("init_ready_high", ready, 1);
    check("preset_reg8", rd1, 32'd17);
    check("reg5_zero", rd2, 32'd0);
    for (int r = 0; r < NREGS; r++) begin
      tick();
      a1 = AW'(r);
      check_all();
      check("busy_after_init", busy1, 0);
    end

    // Same-address write collision: port 1 wins.
    tick();
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAAAA_0001;
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h5555_0002;
    check_all();
    tick(); idle();
    a1 = 5'd3;
    check_all();
    check("write_priority", rd1, 32'h5555_0002);

    // Writes to x0 are dropped, even through the bypass.
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF; a2 = 5'd0;
    check_all();
    check("x0_bypass", rd2, 32'd0);
    tick(); idle();
    check_all();
    check("x0_stored", rd2, 32'd0);

    // Bypass vs. stored-only read of a same-cycle write.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1234; a1 = 5'd7;
    check_all();
    check("bypass_on", rd1, 32'h1234);
    check("bypass_off_old", nb_rd1, 32'd0);
    tick(); idle();
    check_all();
    check("bypass_off_new", nb_rd1, 32'h1234);

    // Scoreboard set / clear / alloc-wins.
    alloc = 1'b1; alloc_addr = 5'd9; a1 = 5'd9;
    check_all();
    check("busy_no_same_cycle", busy1, 0);
    tick(); idle();
    check_all();
    check("alloc_sets", busy1, 1);
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h5;
    tick(); idle();
    check_all();
    check("write_clears", busy1, 0);
    alloc = 1'b1; alloc_addr = 5'd9; we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h42;
    tick(); idle();
    check_all();
    check("alloc_wins_busy", busy1, 1);
    check("alloc_wins_data", rd1, 32'h42);
    alloc = 1'b1; alloc_addr = 5'd0; a2 = 5'd0;
    tick(); idle();
    check_all();
    check("alloc_x0_ignored", busy2, 0);

    // Mid-run reset, with writes attempted throughout the re-init sweep.
    we1 = 1'b1; wa1 = 5'd4; wd1 = 32'hBEEF; alloc = 1'b1; alloc_addr = 5'd6;
    tick(); idle();
    a1 = 5'd4; a2 = 5'd6;
    check_all();
    check("pre_rst_reg4", rd1, 32'hBEEF);
    check("pre_rst_busy6", busy2, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    we1 = 1'b1; wa1 = 5'd4; wd1 = 32'hDEAD;
    for (int i = 0; i < NREGS; i++) begin
      check_all();
      check("reinit_ready_low", ready, 0);
      check("reinit_rd1_zero", rd1, 32'd0);
      tick();
    end
    idle();
    check_all();
    check("reinit_ready_high", ready, 1);
    check("reinit_reg4", rd1, 32'd0);
    check("reinit_busy6", busy2, 0);
    tick();
    a1 = 5'd8;
    check_all();
    check("reinit_preset", rd1, 32'd17);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst        = ($urandom_range(0, 299) == 0);
      a1         = rand_addr();
      a2         = rand_addr();
      we0        = $urandom_range(0, 1) == 1;
      wa0        = rand_addr();
      wd0        = $urandom;
      we1        = $urandom_range(0, 1) == 1;
      wa1        = rand_addr();
      wd1        = $urandom;
      alloc      = $urandom_range(0, 2) == 0;
      alloc_addr = rand_addr();
      check_all();
    end
    tick(); idle();
    check_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
